// File: rtl/fuzz_finish_monitor.sv
// Purpose: end-of-round detector for the fuzz harness. Watches tohost writes and retire stalls and latches a pass/fail verdict.
// Latency: finish rises DRAIN_CYCLES+1 cycles after the tohost beat, or one cycle after the stall counter reaches WDOG_LIMIT.
// Backpressure: none; a write counts only on wr_valid && wr_ready, and wr_ready is never driven by this block.
//
// Ports:
//   clock, reset          - core clock, synchronous active-low reset
//   wr_valid/ready/addr/data - observed memory write port (beat accepted on valid && ready)
//   retire_valid          - one instruction retired this cycle
//   finish                - level, round complete, held until reset
//   fail/fail_code/timeout - verdict, frozen once finish is high
//   retire_count/cycle_count - round statistics, frozen once finish is high
module fuzz_finish_monitor #(
    parameter int unsigned             ADDR_W       = 32,
    parameter int unsigned             DATA_W       = 64,
    parameter logic [ADDR_W-1:0]       TOHOST_ADDR  = 32'h8000_1000,
    parameter int unsigned             DRAIN_CYCLES = 8,
    parameter int unsigned             WDOG_W       = 20,
    parameter logic [WDOG_W-1:0]       WDOG_LIMIT   = 20'hF_FFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_valid,
    input  logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              retire_valid,
    output logic              finish,
    output logic              fail,
    output logic [DATA_W-2:0] fail_code,
    output logic              timeout,
    output logic [63:0]       retire_count,
    output logic [63:0]       cycle_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0]        DRAIN_LOAD = 8'(DRAIN_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = {{(WDOG_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    state_t              state_d;
    logic [7:0]          drain_cnt_q;
    logic [WDOG_W-1:0]   wdog_q;
    logic                fail_q;
    logic [DATA_W-2:0]   code_q;
    logic                timeout_q;
    logic [63:0]         retire_cnt_q;
    logic [63:0]         cycle_cnt_q;

    logic                hit;
    logic                wdog_expired;
    logic                latch_hit;
    logic                latch_timeout;
    logic                load_drain;

    // Only a tohost write with the LSB set ends the round; LSB=0 writes are
    // syscall-style traffic from the test and must not terminate it.
    assign hit          = wr_valid && wr_ready && (wr_addr == TOHOST_ADDR) && wr_data[0];
    assign wdog_expired = (wdog_q == WDOG_LIMIT);

    always_comb begin
        state_d       = state_q;
        latch_hit     = 1'b0;
        latch_timeout = 1'b0;
        load_drain    = 1'b0;
        case (state_q)
            RUN: begin
                // A hit in the same cycle as watchdog expiry wins: the test
                // did report, it just did so at the last moment.
                if (hit) begin
                    latch_hit = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = DRAIN;
                        load_drain = 1'b1;
                    end
                end else if (wdog_expired) begin
                    latch_timeout = 1'b1;
                    state_d       = DONE;
                end
            end
            DRAIN: begin
                if (drain_cnt_q <= 8'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= RUN;
            drain_cnt_q  <= 8'd0;
            wdog_q       <= '0;
            fail_q       <= 1'b0;
            code_q       <= '0;
            timeout_q    <= 1'b0;
            retire_cnt_q <= 64'd0;
            cycle_cnt_q  <= 64'd0;
        end else begin
            state_q <= state_d;

            if (load_drain) begin
                drain_cnt_q <= DRAIN_LOAD;
            end else if (state_q == DRAIN) begin
                drain_cnt_q <= drain_cnt_q - 8'd1;
            end

            // Stall counter saturates so it can never wrap back under the limit.
            if (state_q == RUN) begin
                if (retire_valid) begin
                    wdog_q <= '0;
                end else if (wdog_q != WDOG_LIMIT) begin
                    wdog_q <= wdog_q + WDOG_ONE;
                end
            end

            if (latch_hit) begin
                fail_q <= |wr_data[DATA_W-1:1];
                code_q <= wr_data[DATA_W-1:1];
            end else if (latch_timeout) begin
                fail_q    <= 1'b1;
                timeout_q <= 1'b1;
                code_q    <= '1;
            end

            if (state_q != DONE) begin
                cycle_cnt_q <= cycle_cnt_q + 64'd1;
                if (retire_valid) begin
                    retire_cnt_q <= retire_cnt_q + 64'd1;
                end
            end
        end
    end

    assign finish       = (state_q == DONE);
    assign fail         = fail_q;
    assign fail_code    = code_q;
    assign timeout      = timeout_q;
    assign retire_count = retire_cnt_q;
    assign cycle_count  = cycle_cnt_q;

endmodule
